// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / debug-loader) arbiter and sequencer for the single-port unified memory.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the CPU always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clockCPU,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t              state_q;
    logic                owner_q;      // 1 = debug port owns the access
    logic [1:0]          cnt_q;
    logic                cpu_ack_q, dbg_ack_q;
    logic [31:0]         cpu_rdata_q, dbg_rdata_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [31:0]         mem_data_q;
    logic                mem_rden_q, mem_wren_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_q;       // 1 = debug port was granted last
`endif

    logic                win_dbg, sel_we, finish;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic                unused_addr;

    assign unused_addr = ^{cpu_addr[31:ADDR_W], dbg_addr[31:ADDR_W]};

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        win_dbg = dbg_req & (~cpu_req | ~last_q);
`else
        win_dbg = dbg_req & ~cpu_req;
`endif
        sel_we    = win_dbg ? dbg_we    : cpu_we;
        sel_addr  = win_dbg ? dbg_addr[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
        sel_wdata = win_dbg ? dbg_wdata : cpu_wdata;
        // Last memory cycle of the access: a write's ACCESS, or the read's final enable cycle.
        finish = ((state_q == ST_ACCESS) && (mem_wren_q || (RD_LAT == 1)))
               || ((state_q == ST_WAIT) && (cnt_q == 2'd0));
    end

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            cnt_q         <= 2'd0;
            cpu_ack_q     <= 1'b0;
            dbg_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dbg_rdata_q   <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q        <= 1'b1;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner_q       <= win_dbg;
                        mem_address_q <= sel_addr;
                        mem_data_q    <= sel_wdata;
                        mem_wren_q    <= sel_we;
                        mem_rden_q    <= ~sel_we;
                        cnt_q         <= WAIT_INIT;
                        state_q       <= ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q        <= win_dbg;
`endif
                    end
                end
                ST_ACCESS: state_q <= ST_WAIT;
                ST_WAIT:   cnt_q   <= cnt_q - 2'd1;
                ST_DONE:   state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase

            if (finish) begin
                state_q       <= ST_DONE;
                mem_rden_q    <= 1'b0;
                mem_wren_q    <= 1'b0;
                mem_address_q <= '0;
                mem_data_q    <= '0;
                if (owner_q) dbg_ack_q <= 1'b1;
                else         cpu_ack_q <= 1'b1;
                if (mem_rden_q) begin
                    if (owner_q) dbg_rdata_q <= mem_q;
                    else         cpu_rdata_q <= mem_q;
                end
            end
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign dbg_ack     = dbg_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign cpu_stall   = cpu_req & ~cpu_ack_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_rden    = mem_rden_q;
    assign mem_wren    = mem_wren_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port unified instruction/data memory (`ramU`). It sits between the multicycle CPU datapath and the memory. It also serves a second requester: a debug/loader port that reads and writes memory while the CPU runs. The arbiter grants one access at a time, drives the memory port, waits the read latency, returns data with a one-cycle acknowledge, and exposes a stall to the CPU control FSM.

## Interface
- `ADDR_W`, 11: memory address width; `mem_address = addr[ADDR_W-1:0]`, upper bits ignored.
- `RD_LAT`, 1: cycles from `mem_rden` asserted to `mem_q` valid; legal range 1..4.

- `clockCPU`  in  1  clock, all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_req`  in  1  CPU access request (level).
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  CPU address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  registered read data, valid while `cpu_ack`=1 and held until the next CPU read completes.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`, combinational.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/32/32  debug port, same meaning as CPU.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `dbg_rdata`  out  32  registered debug read data.
- `mem_address`  out  ADDR_W  memory address.
- `mem_data`  out  32  memory write data.
- `mem_rden`, `mem_wren`  out  1  memory read/write enables.
- `mem_q`  in  32  memory read data.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - The arbiter samples the requests.
  - If any request is high, it picks a winner, latches the winner's `we`/`addr`/`wdata` and owner ID, and goes to ACCESS.
  - Operand changes after the grant are ignored.
- ACCESS, one cycle:
  - `mem_address` and `mem_data` come from the latched operands.
  - `mem_wren` = latched `we`; `mem_rden` = ~latched `we`.
  - A write goes to DONE. A read goes to WAIT.
- WAIT, RD_LAT-1 cycles with a down-counter (0 cycles if RD_LAT=1):
  - `mem_rden` stays high and the address is held.
  - At the edge leaving the last WAIT/ACCESS cycle of the read, `mem_q` is captured into the owner's rdata register.
  - A read leaves to DONE.
- DONE, one cycle:
  - The owner's `ack` = 1 and memory enables = 0.
  - The next state is always IDLE, giving a one-cycle gap between grants.
- A requester that still holds `req` in IDLE after its `ack` starts a new access.
- A requester dropping `req` before `ack` is a protocol violation. The granted access still completes and `ack` still pulses.
- Only the owner's rdata register updates. The other port's rdata holds its value.
- When neither requester is granted, `mem_address` and `mem_data` are 0.

## Timing
- Reset values:
  - State IDLE; all acks, enables and `cpu_stall` 0.
  - `cpu_rdata`, `dbg_rdata`, `mem_address` and `mem_data` are 0.
  - Last-grant = DBG.
- Reset mid-operation: immediate return to IDLE, enables drop asynchronously, no `ack` issued, and the in-flight access is lost.
- Let `a` = the ACCESS cycle (the cycle after `req` is sampled in IDLE).
  - Write: `mem_wren` high in cycle `a`; `ack` in `a+1`.
  - Read: `mem_rden` high cycles `a`..`a+RD_LAT-1`; rdata captured at end of `a+RD_LAT-1`; `ack` in `a+RD_LAT`.
- Minimum request-to-ack latency, `req` high in cycle `r`:
  - Write: `ack` in `r+2`.
  - Read: `ack` in `r+1+RD_LAT`.
- Back-to-back throughput for one requester:
  - Writes: one every 3 cycles.
  - Reads: one every RD_LAT+2 cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - When both requests are high in IDLE, the requester not granted last wins.
  - Last-grant updates on every grant.
- `ARB_ROUND_ROBIN_EN` undefined:
  - The CPU always wins ties and the last-grant register is not implemented.
  - The debug port is served only in IDLE cycles with `cpu_req`=0.

## Test plan
- Reset, then CPU read of addr 0x40 holding 0xDEADBEEF, RD_LAT=1 → `mem_rden` high one cycle with `mem_address`=0x040; `cpu_ack` 2 cycles after req; `cpu_rdata`=0xDEADBEEF; `cpu_stall` high until the `ack` cycle.
- CPU write 0x12345678 to 0x80, then read 0x80 → `mem_wren` one cycle, `ack` at +2; the read returns 0x12345678.
- RD_LAT=3, debug read → `mem_rden` high 3 cycles with the address held; `dbg_ack` at +4; `cpu_rdata` unchanged.
- Both requests held high continuously for 4 grants:
  - With `ARB_ROUND_ROBIN_EN`: grant order CPU, DBG, CPU, DBG.
  - Without it: all four grants go to CPU, with no `dbg_ack`.
- `cpu_addr` changed to 0x100 the cycle after grant of 0x40 → memory sees 0x040 only.
- Assert reset during WAIT (RD_LAT=3) → enables 0 immediately, no `ack`, state IDLE; a fresh request afterwards completes normally.
